sequenciador_melodia: RTL and testbench

- Controller that sequences the buzzer note generator: buffers a queue of notes (note index, tone bank, duration) and plays them back one after another.
- Drives the buzzer's seletor/tom/toca inputs with fixed timing and an inter-note gap.
- Sits between the game/control FSM (producer of notes) and the buzzer.
- Supports streaming: new notes may be queued while playback runs.

---
 rtl/sequenciador_melodia_if.sv | 34 +++
 rtl/sequenciador_melodia.sv | 148 ++++++++++++++
 tb/tb_sequenciador_melodia.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_melodia_if.sv
// Note-sequencer bus: producer side (iniciar/parar/escreve + note fields,
// cheia/vazia status) and buzzer side (seletor/tom/toca) plus playback status.
// Modports:
//   master - game/control FSM (drives commands and notes, reads status)
//   slave  - the sequencer itself
interface sequenciador_melodia_if #(
  parameter int TOM = 4
);
  localparam int TW = (TOM > 1) ? $clog2(TOM) : 1;

  logic          iniciar;
  logic          parar;
  logic          escreve;
  logic [3:0]    nota_in;
  logic [TW-1:0] tom_in;
  logic [7:0]    duracao_in;
  logic          cheia;
  logic          vazia;
  logic [3:0]    seletor;
  logic [TW-1:0] tom;
  logic          toca;
  logic          tocando;
  logic          fim;

  modport master (
    output iniciar, parar, escreve, nota_in, tom_in, duracao_in,
    input  cheia, vazia, seletor, tom, toca, tocando, fim
  );

  modport slave (
    input  iniciar, parar, escreve, nota_in, tom_in, duracao_in,
    output cheia, vazia, seletor, tom, toca, tocando, fim
  );
endinterface

// File: rtl/sequenciador_melodia.sv
// Melody sequencer: buffers {note, tone bank, duration} entries in a circular
// FIFO and plays them back on the buzzer (seletor/tom/toca), each note followed
// by a silent gap. Notes may be queued while playback runs.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-high; clears queue, FSM and outputs
//   bus   - sequenciador_melodia_if.slave (commands, note input, queue status,
//           buzzer drive, tocando/fim status)
module sequenciador_melodia #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int TOM         = 4,
  parameter int DEPTH       = 16,
  parameter int UNIT_CYCLES = CLOCK_FREQ / 100,
  parameter int GAP_UNITS   = 1
) (
  input logic                   clock,
  input logic                   reset,
  sequenciador_melodia_if.slave bus
);
  localparam int TW  = (TOM > 1) ? $clog2(TOM) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int CYW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int EW  = 4 + TW + 8;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] CARREGA = 3'd1;
  localparam logic [2:0] NOTA    = 3'd2;
  localparam logic [2:0] PAUSA   = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  logic [EW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_state;
  logic [7:0]     r_dur;
  logic [CYW-1:0] r_cyc;
  logic [7:0]     r_unit;
  logic [3:0]     r_seletor;
  logic [TW-1:0]  r_tom;
  logic           r_toca, r_tocando, r_fim, r_cheia, r_vazia;

  logic           w_push, w_pop, w_cyc_last;
  logic [CW-1:0]  w_cnt_n;
  logic [2:0]     w_state_n;
  logic [EW-1:0]  w_head;
  logic [3:0]     w_head_nota, w_sel_n;
  logic [TW-1:0]  w_head_tom;
  logic [7:0]     w_head_dur;

  assign w_head      = r_mem[r_rd];
  assign w_head_nota = w_head[EW-1 -: 4];
  assign w_head_tom  = w_head[8 +: TW];
  assign w_head_dur  = w_head[7:0];

  assign w_push     = bus.escreve && !r_cheia && !bus.parar;
  assign w_pop      = (r_state == CARREGA) && !r_vazia && !bus.parar;
  assign w_cnt_n    = bus.parar ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));
  assign w_cyc_last = (r_cyc == CYW'(UNIT_CYCLES - 1));
  assign w_sel_n    = w_pop ? w_head_nota : r_seletor;

  // End-of-gap and skip decisions look at the post-edge count, so a note
  // pushed on the very last gap cycle is still picked up without delay.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      OCIOSO:  if (bus.iniciar && !r_vazia) w_state_n = CARREGA;
      CARREGA: begin
        if (w_head_dur == 8'd0) w_state_n = (w_cnt_n != '0) ? CARREGA : FIM;
        else                    w_state_n = NOTA;
      end
      NOTA:    if (w_cyc_last && (r_unit == r_dur - 8'd1)) w_state_n = PAUSA;
      PAUSA:   if (w_cyc_last && (r_unit == 8'(GAP_UNITS - 1)))
                 w_state_n = (w_cnt_n != '0) ? CARREGA : FIM;
      FIM:     w_state_n = OCIOSO;
      default: w_state_n = OCIOSO;
    endcase
    if (bus.parar) w_state_n = OCIOSO;
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= {bus.nota_in, bus.tom_in, bus.duracao_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_state   <= OCIOSO;
      r_dur     <= '0;
      r_cyc     <= '0;
      r_unit    <= '0;
      r_seletor <= '0;
      r_tom     <= '0;
      r_toca    <= 1'b0;
      r_tocando <= 1'b0;
      r_fim     <= 1'b0;
      r_cheia   <= 1'b0;
      r_vazia   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cheia <= (w_cnt_n == CW'(DEPTH));
      r_vazia <= (w_cnt_n == '0);

      if (bus.parar) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
      end

      if (w_pop) begin
        r_seletor <= w_head_nota;
        r_tom     <= w_head_tom;
        r_dur     <= w_head_dur;
      end

      // Counters run only while dwelling in NOTA/PAUSA; any transition
      // (including NOTA->PAUSA) restarts them from zero.
      if (((r_state == NOTA) || (r_state == PAUSA)) && (w_state_n == r_state)) begin
        if (w_cyc_last) begin
          r_cyc  <= '0;
          r_unit <= r_unit + 8'd1;
        end else begin
          r_cyc <= r_cyc + CYW'(1);
        end
      end else begin
        r_cyc  <= '0;
        r_unit <= '0;
      end

      r_toca    <= (w_state_n == NOTA) && (w_sel_n < 4'd12);
      r_tocando <= (w_state_n != OCIOSO);
      r_fim     <= (w_state_n == FIM);
    end
  end

  assign bus.seletor = r_seletor;
  assign bus.tom     = r_tom;
  assign bus.toca    = r_toca;
  assign bus.tocando = r_tocando;
  assign bus.fim     = r_fim;
  assign bus.cheia   = r_cheia;
  assign bus.vazia   = r_vazia;
endmodule

// File: tb/tb_sequenciador_melodia.sv
module tb_sequenciador_melodia;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  sequenciador_melodia_if #(.TOM(4)) bus ();

  sequenciador_melodia #(
    .CLOCK_FREQ (1000),
    .TOM        (4),
    .DEPTH      (4),
    .UNIT_CYCLES(10),
    .GAP_UNITS  (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       esc, ini, par;
    logic [3:0] nota;
    logic [1:0] tom;
    logic [7:0] dur;
    logic       e_cheia, e_vazia, e_tocando, e_toca;
    logic [3:0] e_sel;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_state(input string nm, input logic e_toca, input logic [3:0] e_sel,
                           input logic [1:0] e_tom, input logic e_tocando, input logic e_fim);
    chk({nm, ".toca"},    32'(bus.toca),    32'(e_toca));
    chk({nm, ".seletor"}, 32'(bus.seletor), 32'(e_sel));
    chk({nm, ".tom"},     32'(bus.tom),     32'(e_tom));
    chk({nm, ".tocando"}, 32'(bus.tocando), 32'(e_tocando));
    chk({nm, ".fim"},     32'(bus.fim),     32'(e_fim));
  endtask

  task automatic phase(input string nm, input int n, input logic e_toca,
                       input logic [3:0] e_sel, input logic [1:0] e_tom);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk_state($sformatf("%s[%0d]", nm, i), e_toca, e_sel, e_tom, 1'b1, 1'b0);
    end
  endtask

  task automatic push(input logic [3:0] n, input logic [1:0] t, input logic [7:0] d);
    bus.escreve = 1'b1; bus.nota_in = n; bus.tom_in = t; bus.duracao_in = d;
    cyc();
    bus.escreve = 1'b0;
  endtask

  task automatic start();
    bus.iniciar = 1'b1;
    cyc();
    bus.iniciar = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.iniciar = 1'b0; bus.parar = 1'b0; bus.escreve = 1'b0;
    bus.nota_in = '0; bus.tom_in = '0; bus.duracao_in = '0;

    // order: esc ini par nota tom dur | cheia vazia tocando toca sel
    tbl[0]  = '{1, 0, 0, 5, 2, 3, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 3, 3, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 9, 0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 5};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 5};
    tbl[9]  = '{1, 0, 1, 4, 0, 2, 0, 1, 0, 0, 5};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 5};

    // reset values
    cyc(); cyc();
    chk_state("rst", 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    chk("rst.cheia", 32'(bus.cheia), 32'd0);
    chk("rst.vazia", 32'(bus.vazia), 32'd1);
    reset = 1'b0;
    cyc();

    // table: fill to full, overflow, start, abort, ignored iniciar, push+parar
    for (int i = 0; i < 11; i++) begin
      bus.escreve = tbl[i].esc; bus.iniciar = tbl[i].ini; bus.parar = tbl[i].par;
      bus.nota_in = tbl[i].nota; bus.tom_in = tbl[i].tom; bus.duracao_in = tbl[i].dur;
      cyc();
      chk($sformatf("vec%0d.cheia", i),   32'(bus.cheia),   32'(tbl[i].e_cheia));
      chk($sformatf("vec%0d.vazia", i),   32'(bus.vazia),   32'(tbl[i].e_vazia));
      chk($sformatf("vec%0d.tocando", i), 32'(bus.tocando), 32'(tbl[i].e_tocando));
      chk($sformatf("vec%0d.toca", i),    32'(bus.toca),    32'(tbl[i].e_toca));
      chk($sformatf("vec%0d.seletor", i), 32'(bus.seletor), 32'(tbl[i].e_sel));
      chk($sformatf("vec%0d.fim", i),     32'(bus.fim),     32'd0);
    end
    bus.escreve = 1'b0; bus.iniciar = 1'b0; bus.parar = 1'b0;

    // single note
    do_reset();
    push(4'd5, 2'd2, 8'd3);
    chk("single.vazia", 32'(bus.vazia), 32'd0);
    start();
    chk_state("single.carrega", 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    phase("single.nota", 30, 1'b1, 4'd5, 2'd2);
    phase("single.gap", 10, 1'b0, 4'd5, 2'd2);
    cyc();
    chk_state("single.fim", 1'b0, 4'd5, 2'd2, 1'b1, 1'b1);
    cyc();
    chk_state("single.idle", 1'b0, 4'd5, 2'd2, 1'b0, 1'b0);
    chk("single.vazia_end", 32'(bus.vazia), 32'd1);

    // rest and zero-duration skip
    do_reset();
    push(4'd0, 2'd0, 8'd2);
    push(4'd12, 2'd0, 8'd2);
    push(4'd7, 2'd1, 8'd0);
    push(4'd3, 2'd3, 8'd1);
    start();
    chk_state("seq.carrega0", 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    phase("seq.n0", 20, 1'b1, 4'd0, 2'd0);
    phase("seq.g0", 10, 1'b0, 4'd0, 2'd0);
    cyc();
    chk_state("seq.carrega1", 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    phase("seq.rest", 20, 1'b0, 4'd12, 2'd0);
    phase("seq.g1", 10, 1'b0, 4'd12, 2'd0);
    cyc();
    chk_state("seq.carrega2", 1'b0, 4'd12, 2'd0, 1'b1, 1'b0);
    cyc();
    chk_state("seq.skip", 1'b0, 4'd7, 2'd1, 1'b1, 1'b0);
    phase("seq.n3", 10, 1'b1, 4'd3, 2'd3);
    phase("seq.g3", 10, 1'b0, 4'd3, 2'd3);
    cyc();
    chk_state("seq.fim", 1'b0, 4'd3, 2'd3, 1'b1, 1'b1);
    cyc();
    chk_state("seq.idle", 1'b0, 4'd3, 2'd3, 1'b0, 1'b0);

    // full queue: fifth push dropped, exactly four notes played
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push(4'(k), 2'd0, 8'd1);
      chk($sformatf("full.cheia%0d", k), 32'(bus.cheia), (k >= 4) ? 32'd1 : 32'd0);
    end
    start();
    chk_state("full.carrega1", 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      phase($sformatf("full.n%0d", k), 10, 1'b1, 4'(k), 2'd0);
      phase($sformatf("full.g%0d", k), 10, 1'b0, 4'(k), 2'd0);
      cyc();
      if (k < 4) chk_state($sformatf("full.carrega%0d", k + 1), 1'b0, 4'(k), 2'd0, 1'b1, 1'b0);
      else       chk_state("full.fim", 1'b0, 4'd4, 2'd0, 1'b1, 1'b1);
    end
    cyc();
    chk_state("full.idle", 1'b0, 4'd4, 2'd0, 1'b0, 1'b0);

    // streaming: second note pushed during the gap, no fim in between
    do_reset();
    push(4'd4, 2'd1, 8'd1);
    start();
    chk_state("stream.carrega0", 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    phase("stream.n0", 10, 1'b1, 4'd4, 2'd1);
    phase("stream.g0a", 3, 1'b0, 4'd4, 2'd1);
    bus.escreve = 1'b1; bus.nota_in = 4'd6; bus.tom_in = 2'd2; bus.duracao_in = 8'd1;
    cyc();
    bus.escreve = 1'b0;
    chk_state("stream.g0push", 1'b0, 4'd4, 2'd1, 1'b1, 1'b0);
    phase("stream.g0b", 6, 1'b0, 4'd4, 2'd1);
    cyc();
    chk_state("stream.carrega1", 1'b0, 4'd4, 2'd1, 1'b1, 1'b0);
    phase("stream.n1", 10, 1'b1, 4'd6, 2'd2);
    phase("stream.g1", 10, 1'b0, 4'd6, 2'd2);
    cyc();
    chk_state("stream.fim", 1'b0, 4'd6, 2'd2, 1'b1, 1'b1);

    // abort mid-note
    do_reset();
    push(4'd8, 2'd0, 8'd3);
    push(4'd9, 2'd0, 8'd1);
    start();
    chk_state("abort.carrega", 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    phase("abort.nota", 15, 1'b1, 4'd8, 2'd0);
    bus.parar = 1'b1;
    cyc();
    bus.parar = 1'b0;
    chk_state("abort.stop", 1'b0, 4'd8, 2'd0, 1'b0, 1'b0);
    chk("abort.vazia", 32'(bus.vazia), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_state($sformatf("abort.idle%0d", i), 1'b0, 4'd8, 2'd0, 1'b0, 1'b0);
    end
    start();
    chk("abort.ini_ignored", 32'(bus.tocando), 32'd0);
    cyc();
    chk("abort.ini_toca", 32'(bus.toca), 32'd0);

    // asynchronous reset between edges
    do_reset();
    push(4'd5, 2'd2, 8'd3);
    start();
    phase("areset.nota", 5, 1'b1, 4'd5, 2'd2);
    #1 reset = 1'b1;
    #1;
    chk("areset.toca", 32'(bus.toca), 32'd0);
    chk("areset.tocando", 32'(bus.tocando), 32'd0);
    chk("areset.seletor", 32'(bus.seletor), 32'd0);
    chk("areset.tom", 32'(bus.tom), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("areset.vazia", 32'(bus.vazia), 32'd1);
    chk("areset.tocando_after", 32'(bus.tocando), 32'd0);
    start();
    chk("areset.ocioso", 32'(bus.tocando), 32'd0);
    cyc();
    chk("areset.toca_after", 32'(bus.toca), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
